// File: rtl/ntsc_composite_timing.sv
// NTSC-style composite timing generator: dot divider, raster counters with odd-frame dot skip,
// and a composite sample path whose region/pixel decisions are latched once per dot.
module ntsc_composite_timing #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 341,
    parameter int V_TOTAL      = 262,
    parameter int H_ACTIVE     = 256,
    parameter int V_ACTIVE     = 240,
    parameter int HS_START     = 280,
    parameter int HS_LEN       = 25,
    parameter int VS_START     = 245,
    parameter int VS_LEN       = 3,
    parameter int BURST_START  = 309,
    parameter int BURST_LEN    = 14,
    parameter int VBL_LINE     = 241,
    parameter int SKIP_ODD_DOT = 1,
    parameter int OUT_W        = 8,
    parameter int BLANK_LVL    = 46,
    parameter int BURST_AMP    = 46,
    parameter int LUMA_LO0     = 36,
    parameter int LUMA_LO1     = 60,
    parameter int LUMA_LO2     = 100,
    parameter int LUMA_LO3     = 140,
    parameter int LUMA_HI0     = 80,
    parameter int LUMA_HI1     = 120,
    parameter int LUMA_HI2     = 160,
    parameter int LUMA_HI3     = 200
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             render_en,
    input  logic [5:0]       pix_in,
    output logic             dot_en,
    output logic [8:0]       x_pos,
    output logic [8:0]       y_pos,
    output logic             active,
    output logic             odd_frame,
    output logic [7:0]       frame_cnt,
    output logic             vbl_pulse,
    output logic [OUT_W-1:0] VOUT
);

    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LVL_MAX = (1 << OUT_W) - 1;

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > LVL_MAX) return LVL_MAX;
        return v;
    endfunction

    localparam logic [DW-1:0]    DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [8:0]       X_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0]       X_SKIP     = 9'(H_TOTAL - 2);
    localparam logic [8:0]       Y_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0]       H_ACT9     = 9'(H_ACTIVE);
    localparam logic [8:0]       V_ACT9     = 9'(V_ACTIVE);
    localparam logic [8:0]       VBL9       = 9'(VBL_LINE);
    localparam logic [OUT_W-1:0] BLANK_V    = OUT_W'(clampv(BLANK_LVL));
    localparam logic [OUT_W-1:0] BURST_HI_V = OUT_W'(clampv(BLANK_LVL + BURST_AMP / 2));
    localparam logic [OUT_W-1:0] BURST_LO_V = OUT_W'(clampv(BLANK_LVL - BURST_AMP / 2));
    localparam logic [OUT_W-1:0] LO0_V      = OUT_W'(clampv(LUMA_LO0));
    localparam logic [OUT_W-1:0] LO1_V      = OUT_W'(clampv(LUMA_LO1));
    localparam logic [OUT_W-1:0] LO2_V      = OUT_W'(clampv(LUMA_LO2));
    localparam logic [OUT_W-1:0] LO3_V      = OUT_W'(clampv(LUMA_LO3));
    localparam logic [OUT_W-1:0] HI0_V      = OUT_W'(clampv(LUMA_HI0));
    localparam logic [OUT_W-1:0] HI1_V      = OUT_W'(clampv(LUMA_HI1));
    localparam logic [OUT_W-1:0] HI2_V      = OUT_W'(clampv(LUMA_HI2));
    localparam logic [OUT_W-1:0] HI3_V      = OUT_W'(clampv(LUMA_HI3));

    // Window membership with wrap-around past the end of the line/frame.
    function automatic logic in_win(input logic [8:0] pos, input int start, input int len,
                                    input int total);
        int d;
        d = int'(pos) + total - start;
        if (d >= total) d = d - total;
        return (d < len);
    endfunction

    function automatic logic [OUT_W-1:0] luma_hi(input logic [1:0] lg);
        case (lg)
            2'd0:    return HI0_V;
            2'd1:    return HI1_V;
            2'd2:    return HI2_V;
            default: return HI3_V;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] luma_lo(input logic [1:0] lg);
        case (lg)
            2'd0:    return LO0_V;
            2'd1:    return LO1_V;
            2'd2:    return LO2_V;
            default: return LO3_V;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] level(input logic sync, input logic burst,
                                               input logic act, input logic [5:0] pix,
                                               input logic [3:0] phase);
        logic [3:0] hue;
        logic [1:0] lg;
        int         d;
        hue = pix[3:0];
        lg  = pix[5:4];
        d   = int'(phase) + 12 - int'(hue);
        if (d >= 12) d = d - 12;
        if (sync)               level = '0;
        else if (burst)         level = (phase < 4'd6) ? BURST_HI_V : BURST_LO_V;
        else if (!act)          level = BLANK_V;
        else if (hue == 4'd0)   level = luma_hi(lg);
        else if (hue == 4'd13)  level = luma_lo(lg);
        else if (hue >= 4'd14)  level = BLANK_V;
        else                    level = (d < 6) ? luma_hi(lg) : luma_lo(lg);
    endfunction

    logic [DW-1:0] div_cnt;
    logic [3:0]    ph, ph_nxt;
    logic [8:0]    x_nxt, y_nxt;
    logic          frame_wrap, skip_dot;
    logic          hs_now, vs_now, burst_now;
    logic          sync_q, burst_q, act_q;
    logic [5:0]    pix_q;
    logic          sync_s, burst_s, act_s;
    logic [5:0]    pix_s;

    assign dot_en    = (div_cnt == '0);
    assign ph_nxt    = (ph == 4'd11) ? 4'd0 : ph + 4'd1;
    assign active    = (x_pos < H_ACT9) && (y_pos < V_ACT9);
    assign vbl_pulse = dot_en && (x_pos == 9'd1) && (y_pos == VBL9);
    assign skip_dot  = (SKIP_ODD_DOT != 0) && render_en && odd_frame &&
                       (x_pos == X_SKIP) && (y_pos == Y_LAST);
    assign hs_now    = in_win(x_pos, HS_START, HS_LEN, H_TOTAL);
    assign vs_now    = in_win(y_pos, VS_START, VS_LEN, V_TOTAL);
    assign burst_now = in_win(x_pos, BURST_START, BURST_LEN, H_TOTAL);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            ph      <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            ph      <= ph_nxt;
        end
    end

    always_comb begin
        x_nxt      = x_pos;
        y_nxt      = y_pos;
        frame_wrap = 1'b0;
        if (dot_en) begin
            if (skip_dot) begin
                x_nxt      = '0;
                y_nxt      = '0;
                frame_wrap = 1'b1;
            end else if (x_pos == X_LAST) begin
                x_nxt = '0;
                if (y_pos == Y_LAST) begin
                    y_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nxt = y_pos + 9'd1;
                end
            end else begin
                x_nxt = x_pos + 9'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_pos     <= '0;
            y_pos     <= '0;
            odd_frame <= 1'b0;
            frame_cnt <= '0;
        end else begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            if (frame_wrap) begin
                odd_frame <= ~odd_frame;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // On the dot edge the live decisions are used so the sample appears one CLK later;
    // for the rest of the dot the latched copies hold it while chroma follows the phase.
    assign sync_s  = dot_en ? (hs_now | vs_now) : sync_q;
    assign burst_s = dot_en ? (burst_now & ~vs_now) : burst_q;
    assign act_s   = dot_en ? active : act_q;
    assign pix_s   = dot_en ? pix_in : pix_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q  <= 1'b0;
            burst_q <= 1'b0;
            act_q   <= 1'b0;
            pix_q   <= '0;
            VOUT    <= '0;
        end else begin
            if (dot_en) begin
                sync_q  <= sync_s;
                burst_q <= burst_s;
                act_q   <= act_s;
                pix_q   <= pix_s;
            end
            // Evaluated against the phase that is current while this sample is on VOUT.
            VOUT <= level(sync_s, burst_s, act_s, pix_s, ph_nxt);
        end
    end

endmodule
